sms_power_engine: RTL and testbench

SMS_POWER_ENGINE -- requirements
Module: sms_power_engine

---
 rtl/sms_gf_pkg.sv | 12 +
 rtl/gf_mul.sv | 22 ++
 rtl/sms_power_engine.sv | 105 ++++++++++
 tb/tb_sms_power_engine.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sms_gf_pkg.sv
// Shared GF(2^6) field constants and the power-engine FSM state encoding.
package sms_gf_pkg;
    localparam int         GF_M     = 6;
    localparam logic [6:0] GF_POLY  = 7'h43;
    localparam int         GF_EXP_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/gf_mul.sv
// Combinational GF(2^M) multiplier: shift-and-add with on-the-fly reduction mod POLY.
// Zero latency; purely combinational, no flow control.
module gf_mul #(
    parameter int         M    = 6,
    parameter logic [M:0] POLY = 7'h43
) (
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic [M-1:0] p
);
    logic [M-1:0] sh;

    // sh walks a*z^i, reducing each time the z^M term appears
    always_comb begin
        p  = '0;
        sh = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) p = p ^ sh;
            sh = {sh[M-2:0], 1'b0} ^ (sh[M-1] ? POLY[M-1:0] : '0);
        end
    end
endmodule

// File: rtl/sms_power_engine.sv
// GF(2^M) exponentiation y = x^e by MSB-first square-and-multiply, one exponent bit per cycle.
// Latency EXP_W+1 cycles; with SMS_EXP_SKIP_EN leading zeros of e are skipped. Valid/ready on both sides.
module sms_power_engine
    import sms_gf_pkg::*;
#(
    parameter int         M     = GF_M,
    parameter logic [M:0] POLY  = GF_POLY,
    parameter int         EXP_W = GF_EXP_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [M-1:0]     x,
    input  logic [EXP_W-1:0] e,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [M-1:0]     y,
    output logic             out_valid,
    input  logic             out_ready
);
    localparam int CNT_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

    state_t           state, state_nxt;
    logic [M-1:0]     x_q, acc, acc_sq, acc_nxt, mul_op, y_q;
    logic [EXP_W-1:0] e_q;
    logic [CNT_W-1:0] cnt, cnt_load;
    logic             skip_all;

    gf_mul #(.M(M), .POLY(POLY)) u_sq  (.a(acc),    .b(acc),    .p(acc_sq));
    gf_mul #(.M(M), .POLY(POLY)) u_mul (.a(acc_sq), .b(mul_op), .p(acc_nxt));

    assign mul_op = e_q[cnt] ? x_q : M'(1);

`ifdef SMS_EXP_SKIP_EN
    function automatic logic [CNT_W-1:0] msb_idx(input logic [EXP_W-1:0] v);
        logic [CNT_W-1:0] r;
        r = '0;
        for (int i = 0; i < EXP_W; i++) begin
            if (v[i]) r = CNT_W'(i);
        end
        return r;
    endfunction

    assign cnt_load = msb_idx(e);
    assign skip_all = (e == '0);
`else
    assign cnt_load = CNT_W'(EXP_W - 1);
    assign skip_all = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = skip_all ? DONE : RUN;
            end
            RUN: begin
                if (cnt == '0) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // y is captured once at the end of RUN so it stays put through DONE and IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            e_q <= '0;
            acc <= '0;
            cnt <= '0;
            y_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_q <= x;
                        e_q <= e;
                        acc <= M'(1);
                        cnt <= cnt_load;
                        if (skip_all) y_q <= M'(1);
                    end
                end
                RUN: begin
                    acc <= acc_nxt;
                    if (cnt == '0) y_q <= acc_nxt;
                    else           cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign y = y_q;
endmodule

// File: tb/tb_sms_power_engine.sv
// Self-checking bench for sms_power_engine: protocol/result model plus directed vectors.
module tb_sms_power_engine;
    localparam int         M     = 6;
    localparam int         EXP_W = 6;
    localparam logic [6:0] POLY  = 7'h43;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_ready, out_valid, out_ready;
    logic [5:0] x, e, y;

    always #5 clk = ~clk;

    sms_power_engine #(.M(M), .POLY(POLY), .EXP_W(EXP_W)) dut (
        .clk(clk), .rst(rst), .x(x), .e(e), .in_valid(in_valid), .in_ready(in_ready),
        .y(y), .out_valid(out_valid), .out_ready(out_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // polynomial product then long division by POLY
    function automatic logic [5:0] mdl_mul(input logic [5:0] a, input logic [5:0] b);
        logic [11:0] p;
        p = '0;
        for (int i = 0; i < 6; i++)
            if (b[i]) p = p ^ (12'(a) << i);
        for (int k = 10; k >= 6; k--)
            if (p[k]) p = p ^ (12'(POLY) << (k - 6));
        return p[5:0];
    endfunction

    function automatic logic [5:0] mdl_pow(input logic [5:0] b, input logic [5:0] ex);
        logic [5:0] r;
        r = 6'd1;
        for (int i = 0; i < int'(ex); i++) r = mdl_mul(r, b);
        return r;
    endfunction

    function automatic int mdl_lat(input logic [5:0] ex);
`ifdef SMS_EXP_SKIP_EN
        if (ex == 6'd0) return 1;
        for (int i = 5; i >= 0; i--)
            if (ex[i]) return i + 2;
        return 1;
`else
        return EXP_W + 1;
`endif
    endfunction

    typedef enum {M_IDLE, M_RUN, M_DONE} mph_t;
    mph_t       ph = M_IDLE;
    int         remain = 0;
    logic [5:0] exp_y = '0;
    logic [5:0] y_m = '0;
    bit         mdl_on = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            ph = M_IDLE;
            y_m = '0;
            mdl_on = 1'b1;
        end else if (mdl_on) begin
            case (ph)
                M_IDLE: if (in_valid) begin
                    exp_y  = mdl_pow(x, e);
                    remain = mdl_lat(e) - 1;
                    if (remain == 0) begin
                        ph = M_DONE;
                        y_m = exp_y;
                    end else ph = M_RUN;
                end
                M_RUN: begin
                    remain--;
                    if (remain == 0) begin
                        ph = M_DONE;
                        y_m = exp_y;
                    end
                end
                M_DONE: if (out_ready) ph = M_IDLE;
                default: ph = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mdl_on) begin
            chk("in_ready", int'(in_ready), int'(ph == M_IDLE));
            chk("out_valid", int'(out_valid), int'(ph == M_DONE));
            if (ph != M_RUN) chk("y", int'(y), int'(y_m));
        end
    end

    // Called at a negedge; returns at a negedge right after the output handshake.
    task automatic run_op(input logic [5:0] xv, input logic [5:0] ev, input int hold,
                          output logic [5:0] yres, output int lat);
        x = xv;
        e = ev;
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        x = ~xv;
        e = ~ev;
        lat = 1;
        while (!out_valid && lat < 200) begin
            in_valid = 1'($urandom_range(0, 1));
            x = 6'($urandom);
            e = 6'($urandom);
            @(negedge clk);
            lat++;
        end
        yres = y;
        if (!out_valid) begin
            chk("result_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        repeat (hold) begin
            in_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk("hold_y", int'(y), int'(yres));
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_in_ready", int'(in_ready), 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [5:0] r;
    int         lat;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x = '0;
        e = '0;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", int'(in_ready), 1);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_y", int'(y), 0);
        rst = 1'b0;

        chk("model_2_20", int'(mdl_pow(6'h02, 6'd20)), 'h3C);
        chk("model_2_62", int'(mdl_pow(6'h02, 6'd62)), 'h21);
        chk("model_2_63", int'(mdl_pow(6'h02, 6'd63)), 'h01);

        run_op(6'h02, 6'd20, 0, r, lat);
        chk("y_2_20", int'(r), 'h3C);
`ifdef SMS_EXP_SKIP_EN
        chk("lat_2_20", lat, 6);
`else
        chk("lat_2_20", lat, 7);
`endif
        run_op(6'h02, 6'd62, 0, r, lat);
        chk("y_2_62", int'(r), 'h21);
        run_op(6'h02, 6'd63, 0, r, lat);
        chk("y_2_63", int'(r), 'h01);
        run_op(6'h00, 6'd0, 0, r, lat);
        chk("y_0_0", int'(r), 'h01);
        run_op(6'h00, 6'd20, 0, r, lat);
        chk("y_0_20", int'(r), 'h00);
`ifndef SMS_EXP_SKIP_EN
        chk("lat_0_20", lat, 7);
`endif

        run_op(6'h02, 6'd20, 5, r, lat);
        chk("y_hold_2_20", int'(r), 'h3C);

        // reset during the third RUN cycle
        x = 6'h02;
        e = 6'd20;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_y", int'(y), 0);
        rst = 1'b0;
        run_op(6'h02, 6'd20, 0, r, lat);
        chk("y_after_abort", int'(r), 'h3C);

`ifdef SMS_EXP_SKIP_EN
        run_op(6'h15, 6'd0, 0, r, lat);
        chk("skip_y_e0", int'(r), 'h01);
        chk("skip_lat_e0", lat, 1);
        run_op(6'h02, 6'h05, 0, r, lat);
        chk("skip_y_e5", int'(r), 'h20);
        chk("skip_lat_e5", lat, 4);
        for (int xi = 0; xi < 64; xi++)
            for (int ei = 0; ei < 64; ei++) begin
                run_op(6'(xi), 6'(ei), 0, r, lat);
                chk("sweep_lat", lat, mdl_lat(6'(ei)));
            end
`else
        for (int k = 0; k < 300; k++) begin
            run_op(6'($urandom), 6'($urandom), k % 3, r, lat);
            chk("rand_lat", lat, 7);
        end
`endif

        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
